dual_port_arbiter: RTL and testbench

Two-requester arbiter and sequencer in front of the `dual_port` RAM (separate write port `address_in`/`d_in`/`w` and read port `address_out`/`d_out`/`r`). It grants the RAM's write port and read port independently, each with its own round-robin pointer, so one write and one read can issue per cycle. It drives registered RAM controls, captures read data and returns it per requester. A same-address write/read collision is resolved by forwarding.

---
 rtl/dual_port_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_dual_port_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dual_port_arbiter.sv
// dual_port_arbiter
//   Two-requester arbiter in front of a dual-port RAM with one write port and
//   one read port. Each RAM port has its own round-robin pointer, so one write
//   and one read can issue in the same cycle.
//
//   Handshake: a requester holds req/we/addr/wdata stable while req is high.
//   The transfer happens on the rising edge where req and gnt are both 1.
//   gnt is combinational from req, we and the pointers. It never feeds back
//   into req.
//
//   Ports
//     clk_t, rst_n                    clock, asynchronous active-low reset
//     req0/1, we0/1                   request valid, 1 = write / 0 = read
//     addr0/1 [N], wdata0/1 [M]       request address and write data
//     gnt0/1                          combinational grant
//     rvalid0/1, rdata0/1 [M]         read return: one-cycle pulse, held data
//     ram_w, ram_address_in, ram_d_in registered RAM write port
//     ram_r, ram_address_out          registered RAM read port
//     ram_d_out [M]                   RAM read data (combinational in RAM)
module dual_port_arbiter #(
    parameter int N = 4,
    parameter int M = 4
) (
    input  logic         clk_t,
    input  logic         rst_n,
    input  logic         req0,
    input  logic         req1,
    input  logic         we0,
    input  logic         we1,
    input  logic [N-1:0] addr0,
    input  logic [N-1:0] addr1,
    input  logic [M-1:0] wdata0,
    input  logic [M-1:0] wdata1,
    output logic         gnt0,
    output logic         gnt1,
    output logic         rvalid0,
    output logic         rvalid1,
    output logic [M-1:0] rdata0,
    output logic [M-1:0] rdata1,
    output logic         ram_w,
    output logic         ram_r,
    output logic [N-1:0] ram_address_in,
    output logic [N-1:0] ram_address_out,
    output logic [M-1:0] ram_d_in,
    input  logic [M-1:0] ram_d_out
);

    // Round-robin pointers: 0 prefers requester 0, 1 prefers requester 1.
    logic         rr_w_q, rr_w_d;
    logic         rr_r_q, rr_r_d;

    // Issue stage registers (drive the RAM directly).
    logic         ram_w_q, ram_w_d;
    logic         ram_r_q, ram_r_d;
    logic [N-1:0] ram_address_in_q, ram_address_in_d;
    logic [N-1:0] ram_address_out_q, ram_address_out_d;
    logic [M-1:0] ram_d_in_q, ram_d_in_d;
    logic         rid_q, rid_d;

    // Return stage registers.
    logic         rvalid0_q, rvalid0_d;
    logic         rvalid1_q, rvalid1_d;
    logic [M-1:0] rdata0_q, rdata0_d;
    logic [M-1:0] rdata1_q, rdata1_d;

    logic         wcand0, wcand1, rcand0, rcand1;
    logic         gw0, gw1, gr0, gr1;
    logic         fwd;
    logic [M-1:0] ret_data;

    // Arbitration. A requester is a candidate on exactly one port, so it can
    // never be granted twice in one cycle.
    always_comb begin
        wcand0 = req0 & we0;
        wcand1 = req1 & we1;
        rcand0 = req0 & ~we0;
        rcand1 = req1 & ~we1;
        gw0    = rst_n & wcand0 & (~wcand1 | ~rr_w_q);
        gw1    = rst_n & wcand1 & (~wcand0 |  rr_w_q);
        gr0    = rst_n & rcand0 & (~rcand1 | ~rr_r_q);
        gr1    = rst_n & rcand1 & (~rcand0 |  rr_r_q);
    end

    assign gnt0 = gw0 | gr0;
    assign gnt1 = gw1 | gr1;

    // A write and a read issuing together to the same address: the RAM has
    // not yet stored the new word, so the return stage takes it from the
    // write data register instead.
    assign fwd      = ram_w_q & (ram_address_in_q == ram_address_out_q);
    assign ret_data = fwd ? ram_d_in_q : ram_d_out;

    always_comb begin
        rr_w_d            = rr_w_q;
        rr_r_d            = rr_r_q;
        ram_w_d           = 1'b0;
        ram_r_d           = 1'b0;
        ram_address_in_d  = ram_address_in_q;
        ram_address_out_d = ram_address_out_q;
        ram_d_in_d        = ram_d_in_q;
        rid_d             = rid_q;
        rvalid0_d         = 1'b0;
        rvalid1_d         = 1'b0;
        rdata0_d          = rdata0_q;
        rdata1_d          = rdata1_q;

        // Write issue; pointer moves to the requester that was not served.
        if (gw0) begin
            ram_w_d          = 1'b1;
            ram_address_in_d = addr0;
            ram_d_in_d       = wdata0;
            rr_w_d           = 1'b1;
        end else if (gw1) begin
            ram_w_d          = 1'b1;
            ram_address_in_d = addr1;
            ram_d_in_d       = wdata1;
            rr_w_d           = 1'b0;
        end

        // Read issue; remember who asked so the return goes back to them.
        if (gr0) begin
            ram_r_d           = 1'b1;
            ram_address_out_d = addr0;
            rid_d             = 1'b0;
            rr_r_d            = 1'b1;
        end else if (gr1) begin
            ram_r_d           = 1'b1;
            ram_address_out_d = addr1;
            rid_d             = 1'b1;
            rr_r_d            = 1'b0;
        end

        // Return: capture at the end of the read issue cycle.
        if (ram_r_q) begin
            if (rid_q) begin
                rvalid1_d = 1'b1;
                rdata1_d  = ret_data;
            end else begin
                rvalid0_d = 1'b1;
                rdata0_d  = ret_data;
            end
        end
    end

    always_ff @(posedge clk_t or negedge rst_n) begin
        if (!rst_n) begin
            rr_w_q            <= 1'b0;
            rr_r_q            <= 1'b0;
            ram_w_q           <= 1'b0;
            ram_r_q           <= 1'b0;
            ram_address_in_q  <= '0;
            ram_address_out_q <= '0;
            ram_d_in_q        <= '0;
            rid_q             <= 1'b0;
            rvalid0_q         <= 1'b0;
            rvalid1_q         <= 1'b0;
            rdata0_q          <= '0;
            rdata1_q          <= '0;
        end else begin
            rr_w_q            <= rr_w_d;
            rr_r_q            <= rr_r_d;
            ram_w_q           <= ram_w_d;
            ram_r_q           <= ram_r_d;
            ram_address_in_q  <= ram_address_in_d;
            ram_address_out_q <= ram_address_out_d;
            ram_d_in_q        <= ram_d_in_d;
            rid_q             <= rid_d;
            rvalid0_q         <= rvalid0_d;
            rvalid1_q         <= rvalid1_d;
            rdata0_q          <= rdata0_d;
            rdata1_q          <= rdata1_d;
        end
    end

    assign ram_w           = ram_w_q;
    assign ram_r           = ram_r_q;
    assign ram_address_in  = ram_address_in_q;
    assign ram_address_out = ram_address_out_q;
    assign ram_d_in        = ram_d_in_q;
    assign rvalid0         = rvalid0_q;
    assign rvalid1         = rvalid1_q;
    assign rdata0          = rdata0_q;
    assign rdata1          = rdata1_q;

endmodule

// File: tb/tb_dual_port_arbiter.sv
module tb_dual_port_arbiter;
  localparam int N = 4;
  localparam int M = 4;

  // ---------------- clock / reset ----------------
  logic clk_t = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk_t = ~clk_t;

  int cyc = 0;
  always @(posedge clk_t) cyc <= cyc + 1;

  logic         req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [N-1:0] addr0 = 0, addr1 = 0;
  logic [M-1:0] wdata0 = 0, wdata1 = 0;
  logic         gnt0, gnt1, rvalid0, rvalid1;
  logic [M-1:0] rdata0, rdata1;
  logic         ram_w, ram_r;
  logic [N-1:0] ram_address_in, ram_address_out;
  logic [M-1:0] ram_d_in, ram_d_out;

  dual_port_arbiter #(.N(N), .M(M)) dut (
    .clk_t(clk_t), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
    .ram_w(ram_w), .ram_r(ram_r),
    .ram_address_in(ram_address_in), .ram_address_out(ram_address_out),
    .ram_d_in(ram_d_in), .ram_d_out(ram_d_out)
  );

  // RAM attached to the arbiter: synchronous write, combinational read.
  logic [M-1:0] mem [2**N];
  initial for (int i = 0; i < 2**N; i++) mem[i] = '0;
  always @(posedge clk_t) if (ram_w) mem[ram_address_in] <= ram_d_in;
  assign ram_d_out = mem[ram_address_out];

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [M-1:0] exp_q0[$];
  logic [M-1:0] exp_q1[$];
  int due_q0[$];
  int due_q1[$];
  logic [M-1:0] ref_mem [2**N];
  initial for (int i = 0; i < 2**N; i++) ref_mem[i] = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Return monitor: every rvalid must match the head of its queue, on time.
  always @(negedge clk_t) begin
    if (rst_n) begin
      if (rvalid0) begin
        if (exp_q0.size() == 0) check("rvalid0_unexpected", 1, 0);
        else begin
          check("rdata0", rdata0, exp_q0.pop_front());
          check("rvalid0_cycle", cyc, due_q0.pop_front());
        end
      end else if (due_q0.size() > 0 && due_q0[0] <= cyc) begin
        check("rvalid0_missing", 0, 1);
        void'(exp_q0.pop_front());
        void'(due_q0.pop_front());
      end
      if (rvalid1) begin
        if (exp_q1.size() == 0) check("rvalid1_unexpected", 1, 0);
        else begin
          check("rdata1", rdata1, exp_q1.pop_front());
          check("rvalid1_cycle", cyc, due_q1.pop_front());
        end
      end else if (due_q1.size() > 0 && due_q1[0] <= cyc) begin
        check("rvalid1_missing", 0, 1);
        void'(exp_q1.pop_front());
        void'(due_q1.pop_front());
      end
    end
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic         r0, w0;
    logic [N-1:0] a0;
    logic [M-1:0] d0;
    logic         r1, w1;
    logic [N-1:0] a1;
    logic [M-1:0] d1;
    logic         g0, g1;
  } vec_t;

  function automatic vec_t mk(input logic r0, input logic w0, input logic [3:0] a0,
                              input logic [3:0] d0, input logic r1, input logic w1,
                              input logic [3:0] a1, input logic [3:0] d1,
                              input logic g0, input logic g1);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1;
    return v;
  endfunction

  // Drive one cycle at the falling edge, check grants, and record expected
  // read returns from the reference memory (with same-cycle forwarding).
  task automatic apply_vec(input vec_t v, input bit push_en);
    logic [M-1:0] e;
    @(negedge clk_t);
    req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0;
    req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1;
    #2;
    check("gnt0", gnt0, v.g0);
    check("gnt1", gnt1, v.g1);
    if (push_en) begin
      if (v.g0 && !v.w0) begin
        e = (v.g1 && v.w1 && v.a1 == v.a0) ? v.d1 : ref_mem[v.a0];
        exp_q0.push_back(e);
        due_q0.push_back(cyc + 2);
      end
      if (v.g1 && !v.w1) begin
        e = (v.g0 && v.w0 && v.a0 == v.a1) ? v.d0 : ref_mem[v.a1];
        exp_q1.push_back(e);
        due_q1.push_back(cyc + 2);
      end
    end
    if (v.g0 && v.w0) ref_mem[v.a0] = v.d0;
    if (v.g1 && v.w1) ref_mem[v.a1] = v.d1;
  endtask

  task automatic do_reset();
    @(negedge clk_t);
    rst_n = 1'b0;
    req0 = 0; req1 = 0;
    repeat (3) @(negedge clk_t);
    exp_q0.delete(); exp_q1.delete(); due_q0.delete(); due_q1.delete();
    rst_n = 1'b1;
  endtask

  vec_t tbl[19];
  vec_t idle;

  initial begin
    idle = mk(0, 0, 4'h0, 4'h0, 0, 0, 4'h0, 4'h0, 0, 0);

    // Contention, collision, boundary and mixed-port traffic, from reset.
    tbl[0]  = mk(1, 1, 4'h1, 4'h1, 1, 1, 4'h2, 4'h2, 1, 0);
    tbl[1]  = mk(1, 1, 4'h1, 4'h1, 1, 1, 4'h2, 4'h2, 0, 1);
    tbl[2]  = mk(1, 1, 4'h1, 4'h1, 1, 1, 4'h2, 4'h2, 1, 0);
    tbl[3]  = mk(1, 1, 4'h1, 4'h1, 1, 1, 4'h2, 4'h2, 0, 1);
    tbl[4]  = mk(1, 0, 4'h1, 4'h0, 1, 0, 4'h2, 4'h0, 1, 0);
    tbl[5]  = mk(1, 0, 4'h1, 4'h0, 1, 0, 4'h2, 4'h0, 0, 1);
    tbl[6]  = mk(1, 0, 4'h1, 4'h0, 1, 0, 4'h2, 4'h0, 1, 0);
    tbl[7]  = mk(1, 0, 4'h1, 4'h0, 1, 0, 4'h2, 4'h0, 0, 1);
    tbl[8]  = mk(1, 1, 4'h5, 4'h6, 1, 0, 4'h5, 4'h0, 1, 1);
    tbl[9]  = mk(1, 1, 4'hF, 4'hF, 0, 0, 4'h0, 4'h0, 1, 0);
    tbl[10] = mk(0, 0, 4'h0, 4'h0, 1, 1, 4'h0, 4'h7, 0, 1);
    tbl[11] = mk(1, 0, 4'hF, 4'h0, 0, 0, 4'h0, 4'h0, 1, 0);
    tbl[12] = mk(0, 0, 4'h0, 4'h0, 1, 0, 4'h0, 4'h0, 0, 1);
    tbl[13] = mk(1, 0, 4'h0, 4'h0, 1, 1, 4'h0, 4'h9, 1, 1);
    tbl[14] = mk(1, 0, 4'h5, 4'h0, 1, 0, 4'hF, 4'h0, 0, 1);
    tbl[15] = mk(1, 0, 4'h5, 4'h0, 0, 0, 4'h0, 4'h0, 1, 0);
    tbl[16] = idle;
    tbl[17] = idle;
    tbl[18] = idle;

    // Reset state with both requesters asserting.
    @(negedge clk_t);
    req0 = 1; req1 = 1; we0 = 1; we1 = 1;
    #2;
    check("rst_gnt0", gnt0, 0);
    check("rst_gnt1", gnt1, 0);
    check("rst_ram_w", ram_w, 0);
    check("rst_ram_r", ram_r, 0);
    check("rst_addr_in", ram_address_in, 0);
    check("rst_addr_out", ram_address_out, 0);
    check("rst_d_in", ram_d_in, 0);
    check("rst_rvalid", {rvalid1, rvalid0}, 0);
    check("rst_rdata", {rdata1, rdata0}, 0);
    req0 = 0; req1 = 0;
    @(negedge clk_t);
    rst_n = 1'b1;

    // Write then read with issue-stage checks.
    apply_vec(mk(1, 1, 4'h3, 4'hA, 0, 0, 4'h0, 4'h0, 1, 0), 1);
    apply_vec(idle, 1);
    check("wr_ram_w", ram_w, 1);
    check("wr_addr_in", ram_address_in, 4'h3);
    check("wr_d_in", ram_d_in, 4'hA);
    check("wr_ram_r", ram_r, 0);
    apply_vec(mk(1, 0, 4'h3, 4'h0, 0, 0, 4'h0, 4'h0, 1, 0), 1);
    check("wr_ram_w_drop", ram_w, 0);
    check("wr_addr_hold", ram_address_in, 4'h3);
    apply_vec(idle, 1);
    check("rd_ram_r", ram_r, 1);
    check("rd_addr_out", ram_address_out, 4'h3);
    apply_vec(idle, 1);
    apply_vec(idle, 1);

    // Table from a fresh reset so both pointers start at requester 0.
    do_reset();
    for (int i = 0; i < 19; i++) apply_vec(tbl[i], 1);

    // Reset in the middle of a read: nothing returns, pointers restart.
    apply_vec(mk(1, 0, 4'h3, 4'h0, 0, 0, 4'h0, 4'h0, 1, 0), 0);
    @(negedge clk_t);
    req0 = 0; req1 = 0;
    rst_n = 1'b0;
    #2;
    check("midrst_gnt0", gnt0, 0);
    rst_n = 1'b1;
    @(negedge clk_t);
    #1;
    check("midrst_rvalid0", rvalid0, 0);
    check("midrst_ram_r", ram_r, 0);
    check("midrst_rdata0", rdata0, 0);
    apply_vec(mk(1, 1, 4'h8, 4'h1, 1, 1, 4'h9, 4'h2, 1, 0), 1);
    apply_vec(mk(1, 1, 4'h8, 4'h3, 1, 1, 4'h9, 4'h2, 0, 1), 1);
    apply_vec(mk(1, 0, 4'h8, 4'h0, 1, 0, 4'h9, 4'h0, 1, 0), 1);
    apply_vec(idle, 1);
    apply_vec(idle, 1);
    apply_vec(idle, 1);

    check("drain_q0", exp_q0.size(), 0);
    check("drain_q1", exp_q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
